// File: rtl/fetch_pc_unit.sv
// Fetch-side program counter: sequential +4, stall hold, and EX-driven redirects,
// with one-deep buffering of a redirect that arrives while fetch is stalled.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | no buffered redirect; PC advances, holds, or jumps directly
// ST_PENDING | redirect captured during a stall; applied when Stall drops
module fetch_pc_unit #(
  parameter int PC_W     = 9,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  output logic [PC_W-1:0]  PC,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Redirect_Pending,
  output logic             Misalign_Err,
  output logic [CNT_W-1:0] Redirect_Count
);

  typedef enum logic {ST_RUN, ST_PENDING} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pend_tgt;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_count;

  logic [PC_W-1:0]   w_tgt;
  logic [PC_W-1:0]   w_pc_inc;
  logic              w_unused_brpc_hi;

  // Target address bits above the PC width carry no meaning for this memory.
  assign w_tgt            = {BrPC[PC_W-1:2], 2'b00};
  assign w_pc_inc         = r_pc + PC_W'(4);
  assign w_unused_brpc_hi = ^BrPC[31:PC_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= PC_W'(RESET_PC);
      r_pend_tgt <= '0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      if (PcSel && (BrPC[1:0] != 2'b00))
        r_misalign <= 1'b1;
      if (PcSel && (r_count != {CNT_W{1'b1}}))
        r_count <= r_count + CNT_W'(1);

      case (r_state)
        ST_RUN: begin
          if (PcSel) begin
            if (Stall) begin
              r_pend_tgt <= w_tgt;
              r_state    <= ST_PENDING;
            end else begin
              r_pc <= w_tgt;
            end
          end else if (!Stall) begin
            r_pc <= w_pc_inc;
          end
        end
        ST_PENDING: begin
          // A newer redirect always supersedes the buffered one.
          if (PcSel) begin
            if (Stall) begin
              r_pend_tgt <= w_tgt;
            end else begin
              r_pc    <= w_tgt;
              r_state <= ST_RUN;
            end
          end else if (!Stall) begin
            r_pc    <= r_pend_tgt;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Wrong-path squash happens in the cycle the redirect is presented, stalled or not.
  assign Flush_IF_ID      = PcSel;
  assign Flush_ID_EX      = PcSel;
  assign PC               = r_pc;
  assign Redirect_Pending = (r_state == ST_PENDING);
  assign Misalign_Err     = r_misalign;
  assign Redirect_Count   = r_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a randomized run, all checked
// against a cycle-level reference model of the PC/redirect rules.
module tb_fetch_pc_unit;

  localparam int PC_W   = 9;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             Stall;
  logic             PcSel;
  logic [31:0]      BrPC;
  logic [PC_W-1:0]  PC;
  logic             Flush_IF_ID;
  logic             Flush_ID_EX;
  logic             Redirect_Pending;
  logic             Misalign_Err;
  logic [CNT_W-1:0] Redirect_Count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned exp_pc;
  int unsigned pend_q[$];
  bit          exp_mis;
  int          exp_cnt;

  fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .Stall            (Stall),
    .PcSel            (PcSel),
    .BrPC             (BrPC),
    .PC               (PC),
    .Flush_IF_ID      (Flush_IF_ID),
    .Flush_ID_EX      (Flush_ID_EX),
    .Redirect_Pending (Redirect_Pending),
    .Misalign_Err     (Misalign_Err),
    .Redirect_Count   (Redirect_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic st, input logic ps, input logic [31:0] br);
    Stall = st;
    PcSel = ps;
    BrPC  = br;
    #1;
  endtask

  // Advance one edge and update the model from the inputs present at that edge.
  task automatic tick();
    int unsigned t;
    @(posedge clk);
    if (reset) begin
      exp_pc  = 0;
      pend_q.delete();
      exp_mis = 0;
      exp_cnt = 0;
    end else begin
      t = BrPC % 512;
      t = t - (t % 4);
      if (PcSel) begin
        exp_cnt = (exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1;
        if (BrPC % 4 != 0) exp_mis = 1;
      end
      if (Stall) begin
        if (PcSel) begin
          pend_q.delete();
          pend_q.push_back(t);
        end
      end else begin
        if (PcSel)               exp_pc = t;
        else if (pend_q.size())  exp_pc = pend_q[0];
        else                     exp_pc = (exp_pc + 4) % 512;
        pend_q.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned seq [4] = '{32'h000, 32'h004, 32'h008, 32'h00C};
    do_reset();
    checks++;
    if (PC !== 9'h000 || Redirect_Pending !== 1'b0 || Misalign_Err !== 1'b0 || Redirect_Count !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: PC=%h pend=%b mis=%b cnt=%0d, required PC=000 pend=0 mis=0 cnt=0",
               PC, Redirect_Pending, Misalign_Err, Redirect_Count);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 32'h0);
      checks++;
      if (PC !== seq[i][8:0] || Flush_IF_ID !== 1'b0 || Flush_ID_EX !== 1'b0) begin
        failures++;
        $display("FAIL seq_inc[%0d]: PC=%h flush=%b%b, required PC=%h flush=00",
                 i, PC, Flush_IF_ID, Flush_ID_EX, seq[i][8:0]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int budget = 200;
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    while (exp_pc != 32'h1FC && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (PC !== 9'h1FC) begin
      failures++;
      $display("FAIL wrap_pre: PC=%h, required 1fc", PC);
    end
    tick();
    checks++;
    if (PC !== 9'h000) begin
      failures++;
      $display("FAIL wrap: PC=%h, required 000", PC);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    repeat (4) tick();
    apply(1'b0, 1'b1, 32'h0000_0240);
    checks++;
    if (PC !== 9'h010 || Flush_IF_ID !== 1'b1 || Flush_ID_EX !== 1'b1) begin
      failures++;
      $display("FAIL redirect_flush: PC=%h flush=%b%b, required PC=010 flush=11",
               PC, Flush_IF_ID, Flush_ID_EX);
    end
    tick();
    apply(1'b0, 1'b0, 32'h0);
    checks++;
    if (PC !== 9'h040 || Redirect_Count !== 4'd1 || Misalign_Err !== 1'b0 || Flush_IF_ID !== 1'b0) begin
      failures++;
      $display("FAIL redirect_target: PC=%h cnt=%0d mis=%b flush=%b, required PC=040 cnt=1 mis=0 flush=0",
               PC, Redirect_Count, Misalign_Err, Flush_IF_ID);
    end
  endtask

  task automatic test_stalled_redirect();
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    repeat (8) tick();
    apply(1'b1, 1'b1, 32'h0000_0080);
    checks++;
    if (PC !== 9'h020 || Flush_IF_ID !== 1'b1 || Flush_ID_EX !== 1'b1) begin
      failures++;
      $display("FAIL stall_redir_flush: PC=%h flush=%b%b, required PC=020 flush=11",
               PC, Flush_IF_ID, Flush_ID_EX);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 32'h0);
      checks++;
      if (PC !== 9'h020 || Redirect_Pending !== 1'b1 || Flush_IF_ID !== 1'b0 || Flush_ID_EX !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: PC=%h pend=%b flush=%b%b, required PC=020 pend=1 flush=00",
                 i, PC, Redirect_Pending, Flush_IF_ID, Flush_ID_EX);
      end
      tick();
    end
    apply(1'b0, 1'b0, 32'h0);
    checks++;
    if (PC !== 9'h020 || Redirect_Pending !== 1'b1 || Flush_IF_ID !== 1'b0) begin
      failures++;
      $display("FAIL stall_release_pre: PC=%h pend=%b flush=%b, required PC=020 pend=1 flush=0",
               PC, Redirect_Pending, Flush_IF_ID);
    end
    tick();
    checks++;
    if (PC !== 9'h080 || Redirect_Pending !== 1'b0 || Redirect_Count !== 4'd1) begin
      failures++;
      $display("FAIL stall_release: PC=%h pend=%b cnt=%0d, required PC=080 pend=0 cnt=1",
               PC, Redirect_Pending, Redirect_Count);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    apply(1'b0, 1'b1, 32'h0000_0046);
    tick();
    checks++;
    if (PC !== 9'h044 || Misalign_Err !== 1'b1) begin
      failures++;
      $display("FAIL misalign: PC=%h mis=%b, required PC=044 mis=1", PC, Misalign_Err);
    end
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      if (Misalign_Err !== 1'b1 || PC !== exp_pc[8:0]) begin
        failures++;
        $display("FAIL misalign_sticky[%0d]: mis=%b PC=%h, required mis=1 PC=%h",
                 i, Misalign_Err, PC, exp_pc[8:0]);
      end
    end
    do_reset();
    checks++;
    if (Misalign_Err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_clear: mis=%b, required 0", Misalign_Err);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    apply(1'b1, 1'b1, 32'h0000_0100);
    tick();
    checks++;
    if (Redirect_Pending !== 1'b1 || PC !== 9'h000) begin
      failures++;
      $display("FAIL rstpend_enter: pend=%b PC=%h, required pend=1 PC=000", Redirect_Pending, PC);
    end
    reset = 1'b1;
    apply(1'b1, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    checks++;
    if (PC !== 9'h000 || Redirect_Pending !== 1'b0 || Redirect_Count !== 4'd0) begin
      failures++;
      $display("FAIL rstpend_reset: PC=%h pend=%b cnt=%0d, required PC=000 pend=0 cnt=0",
               PC, Redirect_Pending, Redirect_Count);
    end
    apply(1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (PC !== 9'h004) begin
      failures++;
      $display("FAIL rstpend_discard: PC=%h, required 004", PC);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      apply(1'($urandom_range(0, 1)), 1'b1, $urandom & 32'hFFFF_FFFC);
      tick();
    end
    checks++;
    if (Redirect_Count !== 4'(CNT_MAX) || exp_cnt != CNT_MAX) begin
      failures++;
      $display("FAIL saturate: cnt=%0d, required %0d", Redirect_Count, CNT_MAX);
    end
  endtask

  task automatic test_random();
    logic st, ps;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 99) < 40);
      ps = ($urandom_range(0, 99) < 25);
      apply(st, ps, $urandom);
      checks++;
      if (Flush_IF_ID !== ps || Flush_ID_EX !== ps) begin
        failures++;
        $display("FAIL rand_flush[%0d]: flush=%b%b, required %b%b", i, Flush_IF_ID, Flush_ID_EX, ps, ps);
      end
      tick();
      checks++;
      if (PC !== exp_pc[8:0] || Redirect_Pending !== (pend_q.size() != 0) ||
          Misalign_Err !== exp_mis || Redirect_Count !== exp_cnt[3:0]) begin
        failures++;
        $display("FAIL rand_state[%0d]: PC=%h pend=%b mis=%b cnt=%0d, required PC=%h pend=%b mis=%b cnt=%0d",
                 i, PC, Redirect_Pending, Misalign_Err, Redirect_Count,
                 exp_pc[8:0], (pend_q.size() != 0), exp_mis, exp_cnt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Stall = 1'b0;
    PcSel = 1'b0;
    BrPC  = 32'h0;
    exp_pc = 0;
    exp_mis = 0;
    exp_cnt = 0;
    @(negedge clk);
    test_reset();
    test_wrap();
    test_redirect();
    test_stalled_redirect();
    test_misalign();
    test_reset_pending();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Owns the program counter at the fetch end of the pipeline and consumes the branch-resolution outputs from EX (PcSel, BrPC). It sequences the PC (+4, hold on stall, redirect on taken branch/jump) and squashes wrong-path instructions by pulsing flushes to IF/ID and ID/EX. A redirect that arrives while fetch is stalled is buffered and applied when the stall clears. It also counts accepted redirects for performance monitoring.

Parameters:
PC_W, 9, width of PC and instruction-memory byte address
RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)
CNT_W, 16, width of redirect counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
Stall  in  1  hazard-unit fetch stall (hold PC, freeze IF/ID)
PcSel  in  1  EX redirect request (1 = branch/jump taken)
BrPC  in  32  EX redirect target byte address
PC  out  PC_W  current fetch address (registered)
Flush_IF_ID  out  1  squash IF/ID at next edge (combinational)
Flush_ID_EX  out  1  squash ID/EX at next edge (combinational)
Redirect_Pending  out  1  buffered redirect waiting for Stall to clear (registered)
Misalign_Err  out  1  sticky: a redirect target had BrPC[1:0] != 0
Redirect_Count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (reset=1 at edge): PC=RESET_PC, state RUN, Redirect_Pending=0, pending target=0, Misalign_Err=0, Redirect_Count=0. Reset overrides all other inputs, including mid-pending.
- Target formation: tgt = {BrPC[PC_W-1:2], 2'b00}; BrPC[31:PC_W] ignored (truncated). If PcSel=1 and BrPC[1:0]!=0, Misalign_Err set next edge and stays 1 until reset; redirect still taken with aligned tgt.
- Sequential increment: PC+4 modulo 2^PC_W (e.g. 0x1FC -> 0x000).
- Flush_IF_ID = Flush_ID_EX = PcSel (any state, any Stall); the wrong-path instructions are squashed in the cycle the redirect is presented, regardless of stall.
- Redirect_Count increments by 1 at each edge with PcSel=1 and reset=0; saturates at 2^CNT_W-1.
- State RUN (Redirect_Pending=0):
  - PcSel=1, Stall=0: PC<=tgt; stay RUN.
  - PcSel=1, Stall=1: PC held; pending target<=tgt; go PENDING.
  - PcSel=0, Stall=0: PC<=PC+4.
  - PcSel=0, Stall=1: PC held.
- State PENDING (Redirect_Pending=1):
  - PcSel=0, Stall=1: PC held, pending target held.
  - PcSel=0, Stall=0: PC<=pending target; go RUN. No extra flush.
  - PcSel=1, Stall=1: pending target overwritten with new tgt; stay PENDING.
  - PcSel=1, Stall=0: PC<=new tgt (newest redirect wins); go RUN.
- Redirect_Pending is 1 exactly when state is PENDING.
- Latency: redirect visible on PC one cycle after acceptance (Stall=0), or one cycle after Stall falls when buffered.

Test Plan:
- reset 1 cycle, then Stall=0, PcSel=0 for 4 cycles -> PC 0x000,0x004,0x008,0x00C; all flags 0, count 0.
- Run PC to 0x1FC, Stall=0 -> next PC 0x000 (wrap).
- PC=0x010, PcSel=1, BrPC=0x00000240, Stall=0 -> both flushes 1 that cycle; next PC 0x040; Redirect_Count=1; Misalign_Err=0.
- PC=0x020, Stall=1 with PcSel=1, BrPC=0x80 for one cycle, Stall held 2 more cycles -> flushes 1 only in first cycle; PC stays 0x020; Redirect_Pending=1; Stall=0 -> next PC 0x080, Redirect_Pending=0, no flush.
- PcSel=1, BrPC=0x46, Stall=0 -> next PC 0x044; Misalign_Err=1, remains 1 through 10 normal cycles until reset.
- Enter PENDING (target 0x100), then reset=1 with Stall=1 -> next PC=RESET_PC, Redirect_Pending=0, count 0; after Stall=0 PC increments from 0x000 (buffered target discarded).
